// File: rtl/tmds_channel_encoder.sv
// -----------------------------------------------------------------------------
// tmds_channel_encoder
//   Single-lane TMDS encoder for DVI/HDMI. Encodes one 10-bit symbol per pclk
//   cycle from one of five sources:
//   - control tokens
//   - 8b/10b DC-balanced video
//   - TERC4 data-island nibbles
//   - video guard band
//   - data guard band
//   A signed running-disparity counter keeps the video stream DC balanced. Any
//   non-video symbol clears that counter.
//
// Parameters
//   CHANNEL     lane index 0..2; selects the guard-band symbols.
//   PIPELINE    1 or 2 register stages from input to encoded.
//   DISP_WIDTH  width of the signed disparity counter (>= 5).
//
// Ports
//   pclk          in   1   pixel clock, rising edge.
//   reset         in   1   synchronous, active-high.
//   mode          in   3   0 ctrl, 1 video, 2 data island, 3 video guard,
//                          4 data guard, 5..7 treated as ctrl.
//   control_data  in   2   {c1,c0}.
//   video_data    in   8   pixel component.
//   aux_data      in   4   TERC4 nibble.
//   encoded       out  10  TMDS symbol, bit 0 transmitted first.
//   disparity     out  DISP_WIDTH  running disparity after the current symbol
//                          (present only when TMDS_DISP_MON_EN is defined).
//
// Configuration macro: TMDS_DISP_MON_EN
// -----------------------------------------------------------------------------
module tmds_channel_encoder #(
  parameter int CHANNEL    = 0,
  parameter int PIPELINE   = 1,
  parameter int DISP_WIDTH = 5
) (
  input  logic                  pclk,
  input  logic                  reset,
  input  logic [2:0]            mode,
  input  logic [1:0]            control_data,
  input  logic [7:0]            video_data,
  input  logic [3:0]            aux_data,
  output logic [9:0]            encoded
`ifdef TMDS_DISP_MON_EN
  ,
  output logic [DISP_WIDTH-1:0] disparity
`endif
);

  localparam logic [9:0] C_CTRL00  = 10'b1101010100;
  localparam logic [9:0] C_GUARD_A = 10'b1011001100;
  localparam logic [9:0] C_GUARD_B = 10'b0100110011;
  localparam logic [DISP_WIDTH-1:0] C_ZERO  = {DISP_WIDTH{1'b0}};
  localparam logic [DISP_WIDTH-1:0] C_TWO   = DISP_WIDTH'(2);
  localparam logic [DISP_WIDTH-1:0] C_EIGHT = DISP_WIDTH'(8);

  // Control token table.
  function automatic logic [9:0] f_ctrl(input logic [1:0] c);
    logic [9:0] sym;
    case (c)
      2'd0:    sym = 10'b1101010100;
      2'd1:    sym = 10'b0010101011;
      2'd2:    sym = 10'b0101010100;
      2'd3:    sym = 10'b1010101011;
      default: sym = 10'b1101010100;
    endcase
    return sym;
  endfunction

  // HDMI TERC4 table.
  function automatic logic [9:0] f_terc4(input logic [3:0] a);
    logic [9:0] sym;
    case (a)
      4'h0:    sym = 10'b1010011100;
      4'h1:    sym = 10'b1001100011;
      4'h2:    sym = 10'b1011100100;
      4'h3:    sym = 10'b1011100010;
      4'h4:    sym = 10'b0101110001;
      4'h5:    sym = 10'b0100011110;
      4'h6:    sym = 10'b0110001110;
      4'h7:    sym = 10'b0100111100;
      4'h8:    sym = 10'b1011001100;
      4'h9:    sym = 10'b0100111001;
      4'hA:    sym = 10'b0110011100;
      4'hB:    sym = 10'b1011000110;
      4'hC:    sym = 10'b1010001110;
      4'hD:    sym = 10'b1001110001;
      4'hE:    sym = 10'b0101100011;
      4'hF:    sym = 10'b1011000011;
      default: sym = 10'b1010011100;
    endcase
    return sym;
  endfunction

  // Population count of a byte.
  function automatic logic [3:0] f_popcnt8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  // Transition-minimising stage: XOR or XNOR chain, q_m[8] records which.
  function automatic logic [8:0] f_qm(input logic [7:0] d);
    logic [3:0] n1;
    logic       use_xnor;
    logic [8:0] q;
    n1       = f_popcnt8(d);
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && (d[0] == 1'b0));
    q        = 9'd0;
    q[0]     = d[0];
    for (int i = 1; i < 8; i++) begin
      if (use_xnor) begin
        q[i] = ~(q[i-1] ^ d[i]);
      end else begin
        q[i] = q[i-1] ^ d[i];
      end
    end
    q[8] = ~use_xnor;
    return q;
  endfunction

  logic [8:0]            w_qm_in;
  logic [2:0]            w_mode;
  logic [1:0]            w_ctrl;
  logic [3:0]            w_aux;
  logic [8:0]            w_qm;
  logic [3:0]            w_ones;
  logic [DISP_WIDTH-1:0] w_ones_ext;
  logic [DISP_WIDTH-1:0] w_diff;
  logic [DISP_WIDTH-1:0] w_two_q8;
  logic [DISP_WIDTH-1:0] w_two_nq8;
  logic [9:0]            w_sym_next;
  logic [DISP_WIDTH-1:0] w_cnt_next;
  logic [9:0]            r_encoded;
  logic [DISP_WIDTH-1:0] r_cnt;

  assign w_qm_in = f_qm(video_data);

  generate
    if (PIPELINE == 2) begin : g_pipe2
      logic [2:0] r_mode;
      logic [1:0] r_ctrl;
      logic [3:0] r_aux;
      logic [8:0] r_qm;

      // Stage 1: hold mode, side data and q_m for the final stage.
      always_ff @(posedge pclk) begin
        if (reset) begin
          r_mode <= 3'd0;
          r_ctrl <= 2'd0;
          r_aux  <= 4'd0;
          r_qm   <= 9'd0;
        end else begin
          r_mode <= mode;
          r_ctrl <= control_data;
          r_aux  <= aux_data;
          r_qm   <= w_qm_in;
        end
      end

      assign w_mode = r_mode;
      assign w_ctrl = r_ctrl;
      assign w_aux  = r_aux;
      assign w_qm   = r_qm;
    end else begin : g_pipe1
      assign w_mode = mode;
      assign w_ctrl = control_data;
      assign w_aux  = aux_data;
      assign w_qm   = w_qm_in;
    end
  endgenerate

  // diff = 2*popcount(q_m[7:0]) - 8, signed at DISP_WIDTH.
  assign w_ones     = f_popcnt8(w_qm[7:0]);
  assign w_ones_ext = DISP_WIDTH'(w_ones);
  assign w_diff     = (w_ones_ext << 1) - C_EIGHT;
  assign w_two_q8   = w_qm[8] ? C_TWO : C_ZERO;
  assign w_two_nq8  = w_qm[8] ? C_ZERO : C_TWO;

  // Final stage: symbol select and disparity update, based on the final-stage mode.
  always_comb begin
    w_sym_next = C_CTRL00;
    w_cnt_next = C_ZERO;
    case (w_mode)
      3'd1: begin
        if ((r_cnt == C_ZERO) || (w_diff == C_ZERO)) begin
          w_sym_next = {~w_qm[8], w_qm[8], (w_qm[8] ? w_qm[7:0] : ~w_qm[7:0])};
          if (w_qm[8]) begin
            w_cnt_next = r_cnt + w_diff;
          end else begin
            w_cnt_next = r_cnt - w_diff;
          end
        end else if (r_cnt[DISP_WIDTH-1] == w_diff[DISP_WIDTH-1]) begin
          // Same sign: invert the data bits to pull disparity back to zero.
          w_sym_next = {1'b1, w_qm[8], ~w_qm[7:0]};
          w_cnt_next = r_cnt + w_two_q8 - w_diff;
        end else begin
          w_sym_next = {1'b0, w_qm[8], w_qm[7:0]};
          w_cnt_next = r_cnt + w_diff - w_two_nq8;
        end
      end
      3'd2: begin
        w_sym_next = f_terc4(w_aux);
      end
      3'd3: begin
        if (CHANNEL == 1) begin
          w_sym_next = C_GUARD_B;
        end else begin
          w_sym_next = C_GUARD_A;
        end
      end
      3'd4: begin
        if (CHANNEL == 0) begin
          w_sym_next = f_terc4({2'b11, w_ctrl});
        end else begin
          w_sym_next = C_GUARD_B;
        end
      end
      default: begin
        w_sym_next = f_ctrl(w_ctrl);
      end
    endcase
  end

  // Output symbol and running disparity registers.
  always_ff @(posedge pclk) begin
    if (reset) begin
      r_encoded <= C_CTRL00;
      r_cnt     <= C_ZERO;
    end else begin
      r_encoded <= w_sym_next;
      r_cnt     <= w_cnt_next;
    end
  end

  assign encoded = r_encoded;
`ifdef TMDS_DISP_MON_EN
  assign disparity = r_cnt;
`endif

endmodule
